// File: rtl/tim_pkg.sv
// -----------------------------------------------------------------------------
// tim_pkg
// Shared definitions for the CCD/AFE timing generator.
//   - tim_state_e      : horizontal sequencer state encoding
//   - TIM_H_*          : default horizontal phase lengths (shared with tim_vfsm)
//   - tim_h_phase_len  : number of pixel cycles spent in a given H state
//   - tim_h_succ       : natural successor of a given H state
// -----------------------------------------------------------------------------
package tim_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HD    = 3'd1,
      DUMMY = 3'd2,
      OB    = 3'd3,
      ACT   = 3'd4,
      TRAIL = 3'd5,
      DONE  = 3'd6
   } tim_state_e;

   // Default horizontal line geometry.
   localparam int unsigned TIM_HD_W    = 2;
   localparam int unsigned TIM_H_LEAD  = 12;
   localparam int unsigned TIM_H_OB    = 28;
   localparam int unsigned TIM_H_ACT   = 4008;
   localparam int unsigned TIM_H_TRAIL = 8;
   localparam int unsigned TIM_CW      = 13;

   // Length in cycles of each state. IDLE and DONE count as one cycle so the
   // phase counter is loaded with 0 on entry to them.
   function automatic int unsigned tim_h_phase_len(
      input logic [2:0]  st,
      input int unsigned hd_w,
      input int unsigned h_lead,
      input int unsigned h_ob,
      input int unsigned h_act,
      input int unsigned h_trail
   );
      int unsigned len;
      case (st)
         HD:      len = hd_w;
         DUMMY:   len = h_lead;
         OB:      len = h_ob;
         ACT:     len = h_act;
         TRAIL:   len = h_trail;
         default: len = 1;
      endcase
      return len;
   endfunction

   // Successor in the line sequence IDLE->HD->DUMMY->OB->ACT->TRAIL->DONE->IDLE.
   function automatic logic [2:0] tim_h_succ(input logic [2:0] st);
      logic [2:0] nxt;
      case (st)
         IDLE:    nxt = HD;
         HD:      nxt = DUMMY;
         DUMMY:   nxt = OB;
         OB:      nxt = ACT;
         ACT:     nxt = TRAIL;
         TRAIL:   nxt = DONE;
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/tim_phase_cnt.sv
// -----------------------------------------------------------------------------
// tim_phase_cnt
// Loadable down-counter used to time one phase of a timing FSM.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (counter clears to 0)
//   i_load     : load i_load_val this edge (has priority over decrement)
//   i_load_val : phase length minus one
//   o_zero     : counter currently reads 0 (last cycle of the phase)
// -----------------------------------------------------------------------------
module tim_phase_cnt #(
   parameter int unsigned CW = 13
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   output logic          o_zero
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         // Saturate at zero so an idle FSM holding its state stays parked.
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tim_hfsm.sv
// -----------------------------------------------------------------------------
// tim_hfsm
// Horizontal line sequencer. A line_start pulse in IDLE runs one line:
// HD -> DUMMY -> OB -> ACT -> TRAIL -> DONE, one pixel per clk, then IDLE.
// Ports:
//   clk, rst_n  : pixel clock / asynchronous active-low reset
//   line_start  : one-cycle request to read one line (accepted only in IDLE)
//   abort       : synchronous abort, returns to IDLE from any active state
//   h_run       : H1/H2/RG driver enable (DUMMY..TRAIL)
//   afe_hd      : AFE HD pulse (HD state)
//   afe_pblk    : pixel blanking, low only in DUMMY..TRAIL
//   afe_clpdm   : dummy clamp window (DUMMY)
//   afe_clpob   : optical-black clamp window (OB)
//   cpu_hsync   : active-pixel qualifier (ACT)
//   pix_idx     : active pixel index, 0 outside ACT
//   line_done   : one-cycle end-of-line pulse (DONE)
//   busy        : any state except IDLE
//   overrun     : sticky, line_start seen while busy
// All outputs are registers decoded from the next state, so they line up
// cycle-for-cycle with the state register and never follow inputs directly.
// -----------------------------------------------------------------------------
module tim_hfsm
   import tim_pkg::*;
#(
   parameter int unsigned HD_W    = TIM_HD_W,
   parameter int unsigned H_LEAD  = TIM_H_LEAD,
   parameter int unsigned H_OB    = TIM_H_OB,
   parameter int unsigned H_ACT   = TIM_H_ACT,
   parameter int unsigned H_TRAIL = TIM_H_TRAIL,
   parameter int unsigned CW      = TIM_CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          line_start,
   input  logic          abort,
   output logic          h_run,
   output logic          afe_hd,
   output logic          afe_pblk,
   output logic          afe_clpdm,
   output logic          afe_clpob,
   output logic          cpu_hsync,
   output logic [CW-1:0] pix_idx,
   output logic          line_done,
   output logic          busy,
   output logic          overrun
);

   localparam logic [2:0] ST_IDLE  = IDLE;
   localparam logic [2:0] ST_HD    = HD;
   localparam logic [2:0] ST_DUMMY = DUMMY;
   localparam logic [2:0] ST_OB    = OB;
   localparam logic [2:0] ST_ACT   = ACT;
   localparam logic [2:0] ST_TRAIL = TRAIL;
   localparam logic [2:0] ST_DONE  = DONE;

   logic [2:0]    r_state;
   logic [2:0]    w_next_state;
   logic          w_load;
   logic [CW-1:0] w_load_val;
   logic          w_cnt_zero;
   logic [CW-1:0] w_pix_next;

   logic          r_h_run;
   logic          r_afe_hd;
   logic          r_afe_pblk;
   logic          r_afe_clpdm;
   logic          r_afe_clpob;
   logic          r_cpu_hsync;
   logic [CW-1:0] r_pix_idx;
   logic          r_line_done;
   logic          r_busy;
   logic          r_overrun;

   // ---------------------------------------------------------------------
   // Phase counter: reloaded with (length-1) whenever the state changes.
   // ---------------------------------------------------------------------
   tim_phase_cnt #(
      .CW (CW)
   ) u_phase_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_cnt_zero)
   );

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      if (r_state == ST_IDLE) begin
         // abort has priority over a simultaneous start request.
         if (line_start && !abort) begin
            w_next_state = ST_HD;
            w_load       = 1'b1;
         end
      end else if (abort) begin
         w_next_state = ST_IDLE;
         w_load       = 1'b1;
      end else if (w_cnt_zero) begin
         w_next_state = tim_h_succ(r_state);
         w_load       = 1'b1;
      end
      w_load_val = CW'(tim_h_phase_len(w_next_state, HD_W, H_LEAD, H_OB,
                                       H_ACT, H_TRAIL) - 1);
   end

   // Pixel index restarts at 0 on entry to ACT and counts up while in it.
   always_comb begin
      w_pix_next = '0;
      if (w_next_state == ST_ACT && r_state == ST_ACT) begin
         w_pix_next = r_pix_idx + CW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // State and registered output decode
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_h_run     <= 1'b0;
         r_afe_hd    <= 1'b0;
         r_afe_pblk  <= 1'b1;
         r_afe_clpdm <= 1'b0;
         r_afe_clpob <= 1'b0;
         r_cpu_hsync <= 1'b0;
         r_pix_idx   <= '0;
         r_line_done <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_h_run     <= (w_next_state == ST_DUMMY) || (w_next_state == ST_OB) ||
                        (w_next_state == ST_ACT)   || (w_next_state == ST_TRAIL);
         r_afe_hd    <= (w_next_state == ST_HD);
         r_afe_pblk  <= (w_next_state == ST_IDLE) || (w_next_state == ST_HD) ||
                        (w_next_state == ST_DONE);
         r_afe_clpdm <= (w_next_state == ST_DUMMY);
         r_afe_clpob <= (w_next_state == ST_OB);
         r_cpu_hsync <= (w_next_state == ST_ACT);
         r_pix_idx   <= w_pix_next;
         r_line_done <= (w_next_state == ST_DONE);
         r_busy      <= (w_next_state != ST_IDLE);
         // A request the sequencer cannot honour is latched until reset.
         if (line_start && r_state != ST_IDLE) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign h_run     = r_h_run;
   assign afe_hd    = r_afe_hd;
   assign afe_pblk  = r_afe_pblk;
   assign afe_clpdm = r_afe_clpdm;
   assign afe_clpob = r_afe_clpob;
   assign cpu_hsync = r_cpu_hsync;
   assign pix_idx   = r_pix_idx;
   assign line_done = r_line_done;
   assign busy      = r_busy;
   assign overrun   = r_overrun;

endmodule
